// File: rtl/grad_div_sequencer_if.sv
// Handshake and divider-operand bundle for grad_div_sequencer.
// slave: the sequencer itself. master: the environment (source, divider, consumer).
interface grad_div_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] gradh;
  logic [15:0] gradv;
  logic [23:0] dvdnd;
  logic [15:0] dvisor;
  logic [7:0]  q_in;
  logic [15:0] r_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  ratio;
  logic [15:0] rem;
  logic        zero_f;
  logic        sat_f;
  logic        scaled_f;

  modport slave (
    input  in_valid, gradh, gradv, q_in, r_in, out_ready,
    output in_ready, dvdnd, dvisor, out_valid, ratio, rem, zero_f, sat_f, scaled_f
  );

  modport master (
    output in_valid, gradh, gradv, q_in, r_in, out_ready,
    input  in_ready, dvdnd, dvisor, out_valid, ratio, rem, zero_f, sat_f, scaled_f
  );
endinterface

// File: rtl/grad_div_sequencer.sv
// Front/back end for an external combinational 24/16 divider: forms
// operands from a gradient pair, waits a settle window, captures q/r and
// presents ratio = 256*gh/(gh+gv) with zero/saturation/overflow handling.
module grad_div_sequencer #(
  parameter int SETTLE_CYCLES = 4  // 1..255
) (
  input logic                  clk,
  input logic                  rst,
  grad_div_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0]  state_q,    state_d;
  logic [7:0]  cnt_q,      cnt_d;
  logic [23:0] dvdnd_q,    dvdnd_d;
  logic [15:0] dvisor_q,   dvisor_d;
  logic [7:0]  ratio_q,    ratio_d;
  logic [15:0] rem_q,      rem_d;
  logic        zero_q,     zero_d;
  logic        sat_q,      sat_d;
  logic        scaled_q,   scaled_d;

  logic [16:0] sum;
  logic [15:0] h_op;
  logic [15:0] d_op;
  logic        accept;

  assign accept = (state_q == ST_IDLE) && bus.in_valid;

  // Operand formation: halve both operands when the sum overflows 16 bits
  // so the ratio is preserved and the divisor still fits.
  always_comb begin
    sum  = {1'b0, bus.gradh} + {1'b0, bus.gradv};
    h_op = bus.gradh;
    d_op = sum[15:0];
    if (sum[16]) begin
      h_op = bus.gradh >> 1;
      d_op = sum[16:1];
    end
  end

  // Next-state logic for FSM, settle counter, operands and results.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvdnd_d  = dvdnd_q;
    dvisor_d = dvisor_q;
    ratio_d  = ratio_q;
    rem_d    = rem_q;
    zero_d   = zero_q;
    sat_d    = sat_q;
    scaled_d = scaled_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          zero_d   = (bus.gradh == 16'd0) && (bus.gradv == 16'd0);
          sat_d    = (bus.gradv == 16'd0) && (bus.gradh != 16'd0);
          scaled_d = sum[16];
          // Zero pair: keep the divider away from a zero divisor.
          if (zero_d) begin
            dvdnd_d  = 24'd0;
            dvisor_d = 16'd1;
          end else begin
            dvdnd_d  = {h_op, 8'h00};
            dvisor_d = d_op;
          end
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          if (zero_q) begin
            ratio_d = 8'd0;
            rem_d   = 16'd0;
          end else if (sat_q) begin
            // gv==0 gives a true quotient of 256, which would truncate.
            ratio_d = 8'd255;
            rem_d   = 16'd0;
          end else begin
            ratio_d = bus.q_in;
            rem_d   = bus.r_in;
          end
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      dvdnd_q  <= 24'd0;
      dvisor_q <= 16'd1;
      ratio_q  <= 8'd0;
      rem_q    <= 16'd0;
      zero_q   <= 1'b0;
      sat_q    <= 1'b0;
      scaled_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvdnd_q  <= dvdnd_d;
      dvisor_q <= dvisor_d;
      ratio_q  <= ratio_d;
      rem_q    <= rem_d;
      zero_q   <= zero_d;
      sat_q    <= sat_d;
      scaled_q <= scaled_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.dvdnd     = dvdnd_q;
  assign bus.dvisor    = dvisor_q;
  assign bus.ratio     = ratio_q;
  assign bus.rem       = rem_q;
  assign bus.zero_f    = zero_q;
  assign bus.sat_f     = sat_q;
  assign bus.scaled_f  = scaled_q;

endmodule

// File: tb/tb_grad_div_sequencer.sv
// Directed bench for grad_div_sequencer with a behavioural divider in the loop.
module tb_grad_div_sequencer;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  grad_div_sequencer_if bus();

  grad_div_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural stand-in for the combinational divider.
  logic [23:0] qfull;
  always_comb begin
    qfull    = (bus.dvisor == 16'd0) ? 24'd0 : bus.dvdnd / {8'd0, bus.dvisor};
    bus.q_in = qfull[7:0];
    bus.r_in = (bus.dvisor == 16'd0) ? 16'd0 : 16'(bus.dvdnd % {8'd0, bus.dvisor});
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] gh, gv;
    logic [23:0] e_dvdnd;
    logic [15:0] e_dvisor;
    logic [7:0]  e_ratio;
    logic [15:0] e_rem;
    logic        e_zero, e_sat, e_scaled;
  } vec_t;

  vec_t vecs[6];

  // Spec expression: floor(256*h'/d) with special-case overrides.
  task automatic model(input logic [15:0] gh, input logic [15:0] gv,
                       output logic [7:0] q, output logic [15:0] r);
    logic [16:0] s;
    logic [31:0] h, d, n;
    s = {1'b0, gh} + {1'b0, gv};
    h = s[16] ? 32'(gh >> 1) : 32'(gh);
    d = s[16] ? 32'(s >> 1) : 32'(s[15:0]);
    if (gh == 0 && gv == 0) begin q = 0; r = 0; end
    else if (gv == 0)       begin q = 255; r = 0; end
    else begin
      n = h * 256;
      q = 8'(n / d);
      r = 16'(n % d);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a pair, complete acceptance, wait for out_valid; leaves DUT in OUT.
  task automatic start_txn(input logic [15:0] gh, input logic [15:0] gv, output int lat);
    bus.gradh = gh; bus.gradv = gv; bus.in_valid = 1'b1;
    lat = 0;
    while (!bus.in_ready && lat < 100) begin tick(); lat++; end
    tick();  // acceptance edge
    bus.in_valid = 1'b0;
    chk("in_ready_low_after_accept", bus.in_ready, 0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin tick(); lat++; end
  endtask

  initial begin
    int lat;
    logic [7:0]  mq;
    logic [15:0] mr;
    logic [7:0]  h_ratio;
    logic [15:0] h_rem;
    logic [23:0] h_dvdnd;

    vecs[0] = '{16'd100,   16'd100,   24'd25600,   16'd200,   8'd128, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'd1,     16'd2,     24'd256,     16'd3,     8'd85,  16'd1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'd300,   16'd100,   24'd76800,   16'd400,   8'd192, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'd0,     16'd0,     24'd0,       16'd1,     8'd0,   16'd0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'd500,   16'd0,     24'd128000,  16'd500,   8'd255, 16'd0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'd40000, 16'd40000, 24'd5120000, 16'd40000, 8'd128, 16'd0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; bus.in_valid = 1'b0; bus.gradh = '0; bus.gradv = '0; bus.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_dvdnd", bus.dvdnd, 0);
    chk("rst_dvisor", bus.dvisor, 1);
    chk("rst_ratio", bus.ratio, 0);
    chk("rst_flags", {bus.zero_f, bus.sat_f, bus.scaled_f}, 0);

    // Table-driven transactions with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      start_txn(vecs[i].gh, vecs[i].gv, lat);
      chk("latency", lat, SETTLE);
      chk("dvdnd", bus.dvdnd, vecs[i].e_dvdnd);
      chk("dvisor", bus.dvisor, vecs[i].e_dvisor);
      chk("ratio", bus.ratio, vecs[i].e_ratio);
      chk("rem", bus.rem, vecs[i].e_rem);
      chk("zero_f", bus.zero_f, vecs[i].e_zero);
      chk("sat_f", bus.sat_f, vecs[i].e_sat);
      chk("scaled_f", bus.scaled_f, vecs[i].e_scaled);
      model(vecs[i].gh, vecs[i].gv, mq, mr);
      chk("model_ratio", bus.ratio, mq);
      chk("model_rem", bus.rem, mr);
      tick();  // handshake edge
      chk("idle_after_hs", {bus.in_ready, bus.out_valid}, 2'b10);
    end

    // Back-pressure: hold OUT for 10 cycles, ignore in_valid pulses.
    bus.out_ready = 1'b0;
    start_txn(16'd1, 16'd2, lat);
    chk("bp_latency", lat, SETTLE);
    h_ratio = bus.ratio; h_rem = bus.rem; h_dvdnd = bus.dvdnd;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = c[0]; bus.gradh = 16'd7; bus.gradv = 16'd9;
      tick();
      chk("bp_hold", {bus.out_valid, bus.in_ready, bus.ratio, bus.rem, bus.dvdnd,
                      bus.zero_f, bus.sat_f, bus.scaled_f},
          {1'b1, 1'b0, 8'd85, 16'd1, 24'd256, 3'b000});
    end
    chk("bp_ratio_stable", {bus.ratio, bus.rem}, {h_ratio, h_rem});
    chk("bp_dvdnd_stable", bus.dvdnd, h_dvdnd);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release", {bus.in_ready, bus.out_valid}, 2'b10);
    tick();
    chk("bp_single_hs", {bus.in_ready, bus.out_valid}, 2'b10);

    // Reset mid-SETTLE discards the transaction.
    bus.gradh = 16'd300; bus.gradv = 16'd100; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_state", {bus.in_ready, bus.out_valid}, 2'b10);
    chk("mid_rst_regs", {bus.dvdnd, bus.dvisor, bus.ratio, bus.rem},
        {24'd0, 16'd1, 8'd0, 16'd0});
    chk("mid_rst_flags", {bus.zero_f, bus.sat_f, bus.scaled_f}, 0);
    lat = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.out_valid) lat++;
    end
    chk("mid_rst_no_pulse", lat, 0);
    start_txn(16'd300, 16'd100, lat);
    chk("post_rst_latency", lat, SETTLE);
    chk("post_rst_ratio", bus.ratio, 192);
    chk("post_rst_rem", bus.rem, 0);
    tick();
    chk("post_rst_idle", bus.in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
